// File: rtl/alu_cmd_seq_if.sv
// Command / ALU / response bundle for alu_cmd_seq.
// The slave modport is the sequencer; the master modport is the command
// source that also provides the external combinational ALU and consumes results.
interface alu_cmd_seq_if #(
  parameter int unsigned size = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_op;
  logic [size-1:0] cmd_a;
  logic [size-1:0] cmd_b;

  logic [size-1:0] alu_a;
  logic [size-1:0] alu_b;
  logic [2:0]      alu_func;
  logic [size-1:0] alu_out;
  logic            alu_zero;

  logic            res_valid;
  logic            res_ready;
  logic [size-1:0] res_data;
  logic            res_zero;
  logic            res_err;
  logic [15:0]     done_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_zero, res_ready,
    output cmd_ready, alu_a, alu_b, alu_func, res_valid, res_data, res_zero,
           res_err, done_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_zero, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_func, res_valid, res_data, res_zero,
           res_err, done_count
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: accepts one command, drives registered operands and
// function code to an external combinational ALU, captures the result one
// cycle later and holds it until the consumer takes it.
module alu_cmd_seq #(
  parameter int unsigned size = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_cmd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic            cmd_ready_q;
  logic            res_valid_q;
  logic            res_zero_q;
  logic            res_err_q;
  logic [size-1:0] alu_a_q;
  logic [size-1:0] alu_b_q;
  logic [size-1:0] res_data_q;
  logic [2:0]      alu_func_q;
  logic [3:0]      op_q;
  logic [15:0]     done_count_q;

  logic            legal_d;
  logic [2:0]      func_d;
  logic            ovf_d;
  logic [size-1:0] exec_data_d;
  logic [15:0]     done_count_d;

  // Decode the incoming op: legality and the ALU function it maps onto.
  always_comb begin
    legal_d = (bus.cmd_op <= 4'd7);
    func_d  = 3'd1;
    if (bus.cmd_op <= 4'd5) begin
      func_d = bus.cmd_op[2:0];
    end
  end

  // Form the result captured at the end of EXEC from the ALU outputs.
  always_comb begin
    ovf_d = (alu_a_q[size-1] != alu_b_q[size-1]) &&
            (bus.alu_out[size-1] != alu_a_q[size-1]);
    exec_data_d = bus.alu_out;
    if (op_q == 4'd6) begin
      exec_data_d = {{(size-1){1'b0}}, bus.alu_zero};
    end else if (op_q == 4'd7) begin
      exec_data_d = {{(size-1){1'b0}}, bus.alu_out[size-1] ^ ovf_d};
    end
  end

  // Completion counter advances on every response handshake, wrapping freely.
  always_comb begin
    done_count_d = done_count_q;
    if (state_q == RESP && bus.res_ready) begin
      done_count_d = done_count_q + 16'd1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_func_q   <= '0;
      op_q         <= '0;
      res_data_q   <= '0;
      res_zero_q   <= 1'b0;
      res_err_q    <= 1'b0;
      done_count_q <= '0;
    end else begin
      done_count_q <= done_count_d;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (legal_d) begin
              alu_a_q    <= bus.cmd_a;
              alu_b_q    <= bus.cmd_b;
              alu_func_q <= func_d;
              op_q       <= bus.cmd_op;
              state_q    <= EXEC;
            end else begin
              res_data_q  <= '0;
              res_zero_q  <= 1'b0;
              res_err_q   <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        EXEC: begin
          res_data_q  <= exec_data_d;
          res_zero_q  <= bus.alu_zero;
          res_err_q   <= 1'b0;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_func   = alu_func_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_zero   = res_zero_q;
  assign bus.res_err    = res_err_q;
  assign bus.done_count = done_count_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Testbench for alu_cmd_seq: provides the external ALU, drives directed and
// random commands, and compares responses with an arithmetic reference model.
module tb_alu_cmd_seq;

  localparam int unsigned SZ = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_cmd_seq_if #(.size(SZ)) bus ();

  alu_cmd_seq #(.size(SZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [15:0] exp_count;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [2:0]  exp_func;
  logic [31:0] alu_res;

  // External combinational ALU.
  always_comb begin
    case (bus.alu_func)
      3'd0:    alu_res = bus.alu_a + bus.alu_b;
      3'd1:    alu_res = bus.alu_a - bus.alu_b;
      3'd2:    alu_res = bus.alu_a & bus.alu_b;
      3'd3:    alu_res = bus.alu_a | bus.alu_b;
      3'd4:    alu_res = ~(bus.alu_a | bus.alu_b);
      3'd5:    alu_res = bus.alu_a << bus.alu_b;
      default: alu_res = '0;
    endcase
    bus.alu_out  = alu_res;
    bus.alu_zero = (alu_res == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response straight from the operation definitions.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] d,
                                    output logic z, output logic e);
    e = (op > 4'd7);
    d = '0;
    z = 1'b0;
    case (op)
      4'd0: d = a + b;
      4'd1: d = a - b;
      4'd2: d = a & b;
      4'd3: d = a | b;
      4'd4: d = ~(a | b);
      4'd5: d = (b < 32) ? (a << b[4:0]) : '0;
      4'd6: d = (a == b) ? 32'd1 : 32'd0;
      4'd7: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: d = '0;
    endcase
    if (!e) z = (op >= 4'd6) ? (a == b) : (d == '0);
  endfunction

  // One complete command/response transaction; entered and left at a negedge in IDLE.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned stall);
    logic [31:0] ed;
    logic        ez;
    logic        ee;
    int          lat;
    ref_model(op, a, b, ed, ez, ee);
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.res_ready = (stall == 0);
    @(posedge clk); @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'($urandom());
    bus.cmd_a     = $urandom();
    bus.cmd_b     = $urandom();
    if (!ee) begin
      exp_a    = a;
      exp_b    = b;
      exp_func = (op < 4'd6) ? op[2:0] : 3'd1;
    end
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 6) begin
      chk("alu_func_exec", 32'(bus.alu_func), 32'(exp_func));
      chk("alu_a_exec", bus.alu_a, exp_a);
      chk("alu_b_exec", bus.alu_b, exp_b);
      chk("cmd_ready_exec", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), ee ? 32'd1 : 32'd2);
    for (int unsigned i = 0; i < stall; i++) begin
      chk("res_valid_hold", 32'(bus.res_valid), 32'd1);
      chk("res_data_hold", bus.res_data, ed);
      chk("res_err_hold", 32'(bus.res_err), 32'(ee));
      chk("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'($urandom_range(0, 7));
      @(posedge clk); @(negedge clk);
    end
    chk("res_data", bus.res_data, ed);
    chk("res_zero", 32'(bus.res_zero), 32'(ez));
    chk("res_err", 32'(bus.res_err), 32'(ee));
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.res_ready = 1'b0;
    exp_count++;
    chk("res_valid_after", 32'(bus.res_valid), 32'd0);
    chk("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("done_count", 32'(bus.done_count), 32'(exp_count));
    chk("res_data_after", bus.res_data, ed);
    chk("res_err_after", 32'(bus.res_err), 32'(ee));
    chk("alu_func_after", 32'(bus.alu_func), 32'(exp_func));
    chk("alu_a_after", bus.alu_a, exp_a);
    chk("alu_b_after", bus.alu_b, exp_b);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
    chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
    chk({tag, "_alu_func"}, 32'(bus.alu_func), 32'd0);
    chk({tag, "_res_data"}, bus.res_data, 32'd0);
    chk({tag, "_res_zero"}, 32'(bus.res_zero), 32'd0);
    chk({tag, "_res_err"}, 32'(bus.res_err), 32'd0);
    chk({tag, "_done_count"}, 32'(bus.done_count), 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd0;
    bus.cmd_a     = 32'd3;
    bus.cmd_b     = 32'd4;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b1;
    exp_count     = '0;
    exp_a         = '0;
    exp_b         = '0;
    exp_func      = '0;

    // Directed cases.
    run_cmd(4'd0, 32'd5, 32'd7, 0);
    run_cmd(4'd6, 32'd9, 32'd9, 0);
    run_cmd(4'd1, 32'd9, 32'd9, 1);
    run_cmd(4'd7, 32'h8000_0000, 32'd1, 0);
    run_cmd(4'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2);
    run_cmd(4'd5, 32'd1, 32'd4, 5);
    run_cmd(4'd12, 32'd33, 32'd44, 0);
    run_cmd(4'd15, 32'd1, 32'd2, 3);
    run_cmd(4'd4, 32'h0F0F_0000, 32'h00F0_F0FF, 0);

    // Reset during EXEC with the counter at its top value.
    force dut.done_count_q = 16'hFFFF;
    @(posedge clk); @(negedge clk);
    release dut.done_count_q;
    chk("preload_ffff", 32'(bus.done_count), 32'h0000_FFFF);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd0;
    bus.cmd_a     = 32'd100;
    bus.cmd_b     = 32'd23;
    bus.res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("exec_before_reset", 32'(bus.res_valid), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n         = 1'b1;
    bus.res_ready = 1'b0;
    chk_reset_state("midop_reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      chk("no_resp_after_reset", 32'(bus.res_valid), 32'd0);
    end
    exp_count = '0;
    exp_a     = '0;
    exp_b     = '0;
    exp_func  = '0;
    run_cmd(4'd2, 32'hFFFF_00FF, 32'h0F0F_0F0F, 0);

    // Counter wrap without reset.
    force dut.done_count_q = 16'hFFFE;
    @(posedge clk); @(negedge clk);
    release dut.done_count_q;
    exp_count = 16'hFFFE;
    run_cmd(4'd3, 32'd1, 32'd2, 0);
    run_cmd(4'd9, 32'd1, 32'd2, 1);

    // Random commands.
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom();
      rb  = $urandom();
      if ($urandom_range(0, 3) == 0) rb = ra;
      if (rop == 4'd5) rb = $urandom_range(0, 40);
      run_cmd(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
